// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_W      = 3;
  localparam int unsigned OPCODE_W   = 5;
  localparam int unsigned NUM_STAGES = 3;

  // Scoreboard stage indices
  localparam int unsigned STAGE_EX  = 0;
  localparam int unsigned STAGE_MEM = 1;
  localparam int unsigned STAGE_WB  = 2;

  // One in-flight register write: valid, destination register, producer is a load
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rg;
    logic             ld;
  } sb_entry_t;

  // Empty slot shifted in when no real write enters the pipeline
  function automatic sb_entry_t sb_bubble();
    return '0;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares one scoreboard entry against the decoding instruction's sources.
module hazard_cmp
  import hazard_scoreboard_pkg::*;
(
  input  sb_entry_t        entry_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             rs_valid_i,
  input  logic             rt_valid_i,
  output logic             match_o
);

  // Entry is live and either used source names its destination
  always_comb begin
    match_o = entry_i.v & ((rs_valid_i & (rs_i == entry_i.rg)) |
                           (rt_valid_i & (rt_i == entry_i.rg)));
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: 3-deep shift scoreboard of in-flight writes
// (EX, MEM, WB) that raises stall when the ID instruction needs an
// unavailable register. WB is tracked but never stalls (regfile bypass).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter bit          FORWARDING = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] Rs,
  input  logic [REG_W-1:0] Rt,
  input  logic             RsValid,
  input  logic             RtValid,
  input  logic             writeRegValid,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             pipe_hold,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  sb_entry_t        sb_q [NUM_STAGES];
  sb_entry_t        sb_d [NUM_STAGES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] match;
  logic             stall_d;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_cmp
    hazard_cmp u_cmp (
      .entry_i    (sb_q[g]),
      .rs_i       (Rs),
      .rt_i       (Rt),
      .rs_valid_i (RsValid),
      .rt_valid_i (RtValid),
      .match_o    (match[g])
    );
  end

  // Stall decision: with forwarding only load-use in EX stalls, otherwise any EX/MEM producer
  always_comb begin
    stall_d = 1'b0;
    if (rst_n && id_valid && !flush) begin
      if (FORWARDING) begin
        stall_d = match[STAGE_EX] & sb_q[STAGE_EX].ld;
      end else begin
        stall_d = match[STAGE_EX] | match[STAGE_MEM];
      end
    end
  end

  assign stall       = stall_d;
  assign stall_count = cnt_q;

  // Next-state: hold freezes everything; flush/stall shift in a bubble; else the ID write enters EX
  always_comb begin
    sb_d  = sb_q;
    cnt_d = cnt_q;
    if (!pipe_hold) begin
      sb_d[STAGE_WB]  = sb_q[STAGE_MEM];
      sb_d[STAGE_MEM] = sb_q[STAGE_EX];
      if (flush || stall_d) begin
        sb_d[STAGE_EX] = sb_bubble();
      end else begin
        sb_d[STAGE_EX].v  = id_valid & writeRegValid;
        sb_d[STAGE_EX].rg = id_wr_reg;
        sb_d[STAGE_EX].ld = id_is_load;
      end
      // stall_d is already zero under flush, so flush leaves the counter alone
      if (stall_d && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        sb_q[i] <= sb_bubble();
      end
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-style bench: stimulus pushes expected {stall, stall_count}
// per DUT into a queue; a negedge monitor pops and compares.
// dut 0: FORWARDING=0 CNT_W=16, dut 1: FORWARDING=1 CNT_W=16, dut 2: FORWARDING=0 CNT_W=4.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [2:0] Rs = '0, Rt = '0, id_wr_reg = '0;
  logic       RsValid = 1'b0, RtValid = 1'b0, writeRegValid = 1'b0;
  logic       id_is_load = 1'b0, flush = 1'b0, pipe_hold = 1'b0;

  logic        st0, st1, st2;
  logic [15:0] c0, c1;
  logic [3:0]  c2;

  always #5 clk = ~clk;

  hazard_scoreboard #(.FORWARDING(0), .CNT_W(16)) dut_f0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .Rs(Rs), .Rt(Rt),
    .RsValid(RsValid), .RtValid(RtValid), .writeRegValid(writeRegValid),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush),
    .pipe_hold(pipe_hold), .stall(st0), .stall_count(c0));

  hazard_scoreboard #(.FORWARDING(1), .CNT_W(16)) dut_f1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .Rs(Rs), .Rt(Rt),
    .RsValid(RsValid), .RtValid(RtValid), .writeRegValid(writeRegValid),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush),
    .pipe_hold(pipe_hold), .stall(st1), .stall_count(c1));

  hazard_scoreboard #(.FORWARDING(0), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .Rs(Rs), .Rt(Rt),
    .RsValid(RsValid), .RtValid(RtValid), .writeRegValid(writeRegValid),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush),
    .pipe_hold(pipe_hold), .stall(st2), .stall_count(c2));

  typedef struct {
    int    sel;
    logic  st;
    int    cnt;
    string nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Monitor: compare every pending expectation against the selected DUT
  always @(negedge clk) begin : mon
    exp_t e;
    logic a_st;
    int   a_cnt;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0:       begin a_st = st0; a_cnt = int'(c0); end
        1:       begin a_st = st1; a_cnt = int'(c1); end
        default: begin a_st = st2; a_cnt = int'(c2); end
      endcase
      checks++;
      if (a_st !== e.st || a_cnt != e.cnt) begin
        errors++;
        $display("FAIL %s: dut%0d stall=%0b count=%0d, expected stall=%0b count=%0d",
                 e.nm, e.sel, a_st, a_cnt, e.st, e.cnt);
      end
    end
  end

  task automatic exp(input int sel, input logic st, input int cnt, input string nm);
    exp_t e;
    e.sel = sel; e.st = st; e.cnt = cnt; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic ins(input logic [2:0] rs, input logic rsv, input logic [2:0] rt,
                     input logic rtv, input logic wv, input logic [2:0] wr, input logic ld);
    id_valid = 1'b1; Rs = rs; RsValid = rsv; Rt = rt; RtValid = rtv;
    writeRegValid = wv; id_wr_reg = wr; id_is_load = ld;
  endtask

  task automatic idle();
    id_valid = 1'b0; RsValid = 1'b0; RtValid = 1'b0; writeRegValid = 1'b0;
    id_is_load = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; idle(); tick(); rst_n = 1'b1;
  endtask

  initial begin
    int model;
    int total;
    logic [2:0] src, dst;
    logic st;

    tick(); tick();
    // Reset state: scoreboard empty, stall forced low
    ins(3'd0, 1, 3'd0, 1, 1, 3'd0, 0);
    exp(0, 0, 0, "reset_f0"); exp(1, 0, 0, "reset_f1"); exp(2, 0, 0, "reset_sat");
    tick();

    // FORWARDING=0: ADD R3,R1,R2 then ADD R4,R3,R5 -> 2 stall cycles
    rst_n = 1'b1; idle(); tick();
    ins(3'd1, 1, 3'd2, 1, 1, 3'd3, 0);
    exp(0, 0, 0, "f0_producer");
    tick();
    ins(3'd3, 1, 3'd5, 1, 1, 3'd4, 0);
    exp(0, 1, 0, "f0_stall1"); exp(2, 1, 0, "sat_stall1"); exp(1, 0, 0, "f1_alu_nostall");
    tick();
    exp(0, 1, 1, "f0_stall2");
    tick();
    exp(0, 0, 2, "f0_release"); exp(2, 0, 2, "sat_release"); exp(1, 0, 0, "f1_alu_count");
    tick();
    ins(3'd4, 1, 3'd4, 1, 1, 3'd6, 0);
    exp(0, 1, 2, "f0_consumer_in_ex");
    tick();

    // FORWARDING=1: LD R2,[R1] then ADD R4,R2,R2 -> 1 stall
    do_reset();
    ins(3'd1, 1, 3'd0, 0, 1, 3'd2, 1);
    exp(1, 0, 0, "f1_load");
    tick();
    ins(3'd2, 1, 3'd2, 1, 1, 3'd4, 0);
    exp(1, 1, 0, "f1_loaduse_stall");
    tick();
    exp(1, 0, 1, "f1_loaduse_release");
    tick();
    idle();
    exp(1, 0, 1, "f1_idle");
    tick();
    // ADDI R2 instead of LD -> no stall
    ins(3'd1, 1, 3'd0, 0, 1, 3'd2, 0);
    exp(1, 0, 1, "f1_addi");
    tick();
    ins(3'd2, 1, 3'd2, 1, 1, 3'd4, 0);
    exp(1, 0, 1, "f1_addi_nostall");
    tick();

    // Flush with load-use hazard: no stall, squashed LD never reaches EX
    ins(3'd1, 1, 3'd0, 0, 1, 3'd5, 1);
    exp(1, 0, 1, "flush_producer");
    tick();
    flush = 1'b1;
    ins(3'd5, 1, 3'd0, 0, 1, 3'd6, 1);
    exp(1, 0, 1, "flush_kills_stall");
    tick();
    flush = 1'b0;
    ins(3'd6, 1, 3'd0, 0, 1, 3'd7, 0);
    exp(1, 0, 1, "flush_bubble_in_ex");
    tick();

    // pipe_hold for 3 cycles during a load-use stall
    ins(3'd1, 1, 3'd0, 0, 1, 3'd2, 1);
    exp(1, 0, 1, "hold_producer");
    tick();
    pipe_hold = 1'b1;
    ins(3'd2, 1, 3'd2, 1, 1, 3'd4, 0);
    for (int i = 0; i < 3; i++) begin
      exp(1, 1, 1, "hold_frozen");
      tick();
    end
    pipe_hold = 1'b0;
    exp(1, 1, 1, "hold_released_stall");
    tick();
    exp(1, 0, 2, "hold_one_stall_done");
    tick();

    // Reset mid-stall (FORWARDING=0), dual-source hazard
    do_reset();
    ins(3'd1, 1, 3'd2, 1, 1, 3'd3, 0);
    exp(0, 0, 0, "rst_producer");
    tick();
    ins(3'd3, 1, 3'd3, 1, 1, 3'd4, 0);
    exp(0, 1, 0, "dual_source_stall");
    tick();
    rst_n = 1'b0;
    exp(0, 0, 1, "stall_forced_in_reset");
    tick();
    rst_n = 1'b1;
    exp(0, 0, 0, "cleared_after_reset");
    tick();

    // Saturation: dependent chain through R0.., 11 consumers x 2 stalls = 22
    do_reset();
    ins(3'd0, 0, 3'd0, 0, 1, 3'd0, 0);
    exp(2, 0, 0, "chain_producer");
    tick();
    model = 0;
    total = 0;
    for (int k = 1; k <= 11; k++) begin
      src = 3'(k - 1);
      dst = 3'(k);
      ins(src, 1, src, 1, 1, dst, 0);
      for (int j = 0; j < 3; j++) begin
        st = (j < 2);
        exp(2, st, model, "sat_chain");
        exp(0, st, total, "wide_chain");
        tick();
        if (st) begin
          total++;
          if (model < 15) model++;
        end
      end
    end
    idle();
    exp(2, 0, 15, "sat_final"); exp(0, 0, 22, "wide_final");
    tick();
    tick(); tick();

    // Store (writeRegValid=0) followed by a reader of its register: no hazard
    ins(3'd1, 1, 3'd2, 1, 0, 3'd3, 0);
    exp(0, 0, 22, "store_enters");
    tick();
    ins(3'd3, 1, 3'd3, 1, 1, 3'd4, 0);
    exp(0, 0, 22, "store_no_hazard");
    tick();
    idle();
    tick();

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_drain: pending=%0d, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Decode-stage hazard unit for the 5-stage 16-bit pipeline. It consumes the per-instruction source and destination validity produced by the decode-stage register-usage decoder. It keeps a 3-deep shift scoreboard of in-flight register writes (EX, MEM, WB) and raises `stall` when the decoding instruction reads a register that is not yet available. Its outputs hold PC and IF/ID and turn the ID/EX insertion into a bubble.

## Interface
Parameters:
- `FORWARDING`, 1: 1 means EX/MEM forwarding exists and only load-use stalls; 0 means stall on any EX or MEM producer.
- `CNT_W`, 16: width of the stall performance counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `id_valid` input 1: the ID stage holds a real instruction.
- `Rs`, `Rt` input 3 each: source register numbers.
- `RsValid`, `RtValid` input 1 each: the instruction reads the corresponding source.
- `writeRegValid` input 1: the instruction writes a register.
- `id_wr_reg` input 3: destination register (R7 for JAL/JALR, Rs for STU; resolved upstream).
- `id_is_load` input 1: the instruction is LD.
- `flush` input 1: branch/jump resolved taken; squash the ID instruction.
- `pipe_hold` input 1: memory wait; the whole pipeline is frozen.
- `stall` output 1: hold PC and IF/ID, insert a bubble into ID/EX.
- `stall_count` output CNT_W: saturating count of stall cycles.

## Operation
- Each scoreboard entry (EX, MEM, WB) holds `{v, reg[2:0], ld}`.
- WB is tracked but never causes a stall, because the register file bypasses write-before-read.
- Match for an entry e: `e.v & ((RsValid & Rs==e.reg) | (RtValid & Rt==e.reg))`.
- Stall condition, always gated by `id_valid & ~flush`:
  - FORWARDING=1: stall = match(EX) & EX.ld.
  - FORWARDING=0: stall = match(EX) | match(MEM).
- Per-cycle update, highest priority first:
  1. `!rst_n`: all entries go to v=0 and `stall_count` goes to 0.
  2. `pipe_hold`: no entry moves and the counter is unchanged.
  3. `flush`: EX takes a bubble (v=0), MEM takes EX, WB takes MEM. The counter is unchanged.
  4. `stall`: EX takes a bubble, MEM takes EX, WB takes MEM. The counter increments, saturating at all-ones.
  5. Otherwise: EX takes `{id_valid & writeRegValid, id_wr_reg, id_is_load}`, MEM takes EX, WB takes MEM.
- Register R0 is an ordinary register; it is not special-cased.
- Instructions with `writeRegValid`=0 enter with v=0. This covers stores, branches, J, JR, HALT and NOP.
- A hazard on both Rs and Rt produces the same single stall as a hazard on one source.

## Timing
- `stall` is combinational from the current ID inputs and the registered scoreboard. There is no added latency.
- `stall` is forced to 0 while `rst_n`=0.
- Reset values: `stall`=0, `stall_count`=0, all entries v=0.
- While `pipe_hold`=1, `stall` may be asserted; the consumer holds anyway. The counter does not advance.
- Stall durations for a dependent instruction immediately after its producer:
  - FORWARDING=1, load-use: 1 cycle.
  - FORWARDING=0, any producer: 2 cycles.
  - FORWARDING=0, one independent instruction between producer and consumer: 1 cycle.
- Reset asserted mid-stall clears the scoreboard on that edge. The next cycle has `stall`=0 and no bubble carry-over.
- `flush` and a hazard in the same cycle: `stall`=0, a bubble is inserted, the counter is unchanged.

## Structure
- Shared header:
  - Entry field widths: REG_W=3.
  - Opcode width: 5.
  - Stage index constants: EX=0, MEM=1, WB=2.
- Sub-module `hazard_cmp`: combinational entry-vs-sources comparator, instantiated once per entry.
- The top level holds the shift registers, the priority update logic and the counter.

## Test plan
- FORWARDING=0. Apply `ADD R3,R1,R2`, then `ADD R4,R3,R5`. Required: `stall`=1 for exactly 2 cycles, then the consumer enters EX; `stall_count`=2.
- FORWARDING=1. Apply `LD R2,[R1]`, then `ADD R4,R2,R2`. Required: 1 stall cycle, `stall_count`=1. Replacing the LD with ADDI gives 0 stalls.
- Apply a load-use hazard with `flush`=1 in the same cycle. Required: `stall`=0, EX.v=0 on the next cycle, counter unchanged.
- Apply `pipe_hold`=1 for 3 cycles during a load-use stall. Required: scoreboard frozen, `stall_count` unchanged. When hold is released, exactly 1 stall cycle completes.
- Pull `rst_n` low for 1 cycle mid-stall. Required: all entries v=0, `stall`=0 on the next cycle, `stall_count`=0.
- CNT_W=4. Force 20 consecutive stall cycles using a FORWARDING=0 back-to-back chain. Required: `stall_count` saturates at 15 and never wraps to 0.
